// File: rtl/interrupt_pkg.sv
// =============================================================================
// interrupt_pkg : shared constants, state encoding and vector helper for the
//                 interrupt request arbiter.
// Revision: 1.0
// =============================================================================
`default_nettype none

package interrupt_pkg;

    localparam int unsigned c_NUM_SRC = 4;
    localparam int unsigned c_ID_W    = 2;

    localparam logic [7:0] c_VEC_BASE_DEFAULT = 8'h08;
    localparam logic [7:0] c_VEC_STEP_DEFAULT = 8'h08;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_REQ     = 2'd1;
    localparam state_t c_ST_SERVICE = 2'd2;

    // 8-bit vector arithmetic wraps by construction
    function automatic logic [7:0] vec_of(input logic [7:0] base,
                                          input logic [7:0] step,
                                          input logic [c_ID_W-1:0] idx);
        logic [7:0] w_idx;
        w_idx = {{(8-c_ID_W){1'b0}}, idx};
        return base + (step * w_idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/interrupt_request_arbiter_if.sv
// =============================================================================
// interrupt_request_arbiter_if : request, mask, handshake and grant signals of
//                                the interrupt request arbiter.
// Revision: 1.0
// =============================================================================
`default_nettype none

interface interrupt_request_arbiter_if;
    import interrupt_pkg::*;

    logic [c_NUM_SRC-1:0] req;
    logic                 mask_wr;
    logic [c_NUM_SRC-1:0] mask_data;
    logic                 ie;
    logic                 int_ack;
    logic                 eoi;
    logic                 intr;
    logic [c_ID_W-1:0]    active_id;
    logic [7:0]           vector;
    logic [c_NUM_SRC-1:0] pending;
    logic                 busy;

    modport master (
        output req, mask_wr, mask_data, ie, int_ack, eoi,
        input  intr, active_id, vector, pending, busy
    );

    modport slave (
        input  req, mask_wr, mask_data, ie, int_ack, eoi,
        output intr, active_id, vector, pending, busy
    );

endinterface

`default_nettype wire

// File: rtl/intr_prio_enc.sv
// =============================================================================
// intr_prio_enc : fixed-priority encoder, lowest set index wins.
// Revision: 1.0
// =============================================================================
`default_nettype none

module intr_prio_enc
    import interrupt_pkg::*;
(
    input  logic [c_NUM_SRC-1:0] eligible,
    output logic [c_ID_W-1:0]    index,
    output logic                 valid
);

    // Scan from the top so the lowest set bit is written last
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = c_NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                index = c_ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/interrupt_request_arbiter.sv
// =============================================================================
// interrupt_request_arbiter : edge-latched 4-source fixed-priority arbiter with
//                             request/acknowledge/EOI handshake.
// Revision: 1.0
// =============================================================================
`default_nettype none

module interrupt_request_arbiter
    import interrupt_pkg::*;
#(
    parameter logic [7:0] VEC_BASE = c_VEC_BASE_DEFAULT,
    parameter logic [7:0] VEC_STEP = c_VEC_STEP_DEFAULT
)
(
    input  logic                         clk,
    input  logic                         rst,
    interrupt_request_arbiter_if.slave   bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_NUM_SRC-1:0] r_req_prev;
    logic [c_NUM_SRC-1:0] r_pending;
    logic [c_NUM_SRC-1:0] r_mask;
    logic                 r_intr;
    logic                 r_busy;
    logic [c_ID_W-1:0]    r_active_id;
    logic [7:0]           r_vector;

    logic [c_NUM_SRC-1:0] w_edge;
    logic [c_NUM_SRC-1:0] w_eligible;
    logic [c_NUM_SRC-1:0] w_clr;
    logic [c_ID_W-1:0]    w_win;
    logic                 w_valid;
    logic                 w_grant;
    logic                 w_ack;
    logic                 w_retract;
    logic                 w_done;

    assign w_edge     = bus.req & ~r_req_prev;
    assign w_eligible = r_pending & ~r_mask;
    assign w_clr      = w_ack ? (c_NUM_SRC'(1) << r_active_id) : '0;

    intr_prio_enc u_prio_enc (
        .eligible (w_eligible),
        .index    (w_win),
        .valid    (w_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.ie && w_valid) w_state_nxt = c_ST_REQ;
            end
            c_ST_REQ: begin
                if (bus.int_ack)  w_state_nxt = c_ST_SERVICE;
                else if (!bus.ie) w_state_nxt = c_ST_IDLE;
            end
            c_ST_SERVICE: begin
                if (bus.eoi) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Acknowledge outranks retraction when both arrive together
    always_comb begin
        w_grant   = 1'b0;
        w_ack     = 1'b0;
        w_retract = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            c_ST_IDLE:    w_grant   = bus.ie && w_valid;
            c_ST_REQ: begin
                w_ack     = bus.int_ack;
                w_retract = !bus.int_ack && !bus.ie;
            end
            c_ST_SERVICE: w_done    = bus.eoi;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_prev  <= '1;
            r_pending   <= '0;
            r_mask      <= '0;
            r_intr      <= 1'b0;
            r_busy      <= 1'b0;
            r_active_id <= '0;
            r_vector    <= 8'h00;
        end else begin
            r_req_prev <= bus.req;
            r_pending  <= (r_pending & ~w_clr) | w_edge;
            if (bus.mask_wr) r_mask <= bus.mask_data;
            if (w_grant) begin
                r_intr      <= 1'b1;
                r_active_id <= w_win;
                r_vector    <= vec_of(VEC_BASE, VEC_STEP, w_win);
            end else if (w_ack || w_retract) begin
                r_intr <= 1'b0;
            end
            if (w_ack)       r_busy <= 1'b1;
            else if (w_done) r_busy <= 1'b0;
        end
    end

    assign bus.intr      = r_intr;
    assign bus.busy      = r_busy;
    assign bus.active_id = r_active_id;
    assign bus.vector    = r_vector;
    assign bus.pending   = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_request_arbiter.sv
// =============================================================================
// tb_interrupt_request_arbiter : directed scenarios plus randomized traffic
//                                checked against a behavioural model.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_interrupt_request_arbiter;

    localparam logic [7:0] c_BASE = 8'h08;
    localparam logic [7:0] c_STEP = 8'h08;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    interrupt_request_arbiter_if bus();

    interrupt_request_arbiter #(
        .VEC_BASE (c_BASE),
        .VEC_STEP (c_STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the arbiter is either free, offering a grant, or
    // servicing one; pending bits are a plain set of latched sources.
    logic [3:0] m_pend, m_mask, m_prev;
    logic       m_intr, m_busy;
    int         m_id;
    int         m_vec;
    bit         m_offering, m_servicing;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 4'h0; m_mask = 4'h0; m_prev = 4'hF;
        m_intr = 1'b0; m_busy = 1'b0; m_id = 0; m_vec = 0;
        m_offering = 1'b0; m_servicing = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] edges, clr, elig;
        edges = bus.req & ~m_prev;
        clr   = 4'h0;
        elig  = m_pend & ~m_mask;
        if (m_offering) begin
            if (bus.int_ack) begin
                clr = 4'h0; clr[m_id] = 1'b1;
                m_intr = 1'b0; m_busy = 1'b1;
                m_offering = 1'b0; m_servicing = 1'b1;
            end else if (!bus.ie) begin
                m_intr = 1'b0; m_offering = 1'b0;
            end
        end else if (m_servicing) begin
            if (bus.eoi) begin
                m_busy = 1'b0; m_servicing = 1'b0;
            end
        end else if (bus.ie && elig != 4'h0) begin
            for (int i = 3; i >= 0; i--) if (elig[i]) m_id = i;
            m_vec = (int'(c_BASE) + m_id * int'(c_STEP)) % 256;
            m_intr = 1'b1; m_offering = 1'b1;
        end
        m_pend = (m_pend & ~clr) | edges;
        if (bus.mask_wr) m_mask = bus.mask_data;
        m_prev = bus.req;
    endtask

    task automatic compare_model();
        check_val("intr",      32'(bus.intr),      32'(m_intr));
        check_val("busy",      32'(bus.busy),      32'(m_busy));
        check_val("active_id", 32'(bus.active_id), 32'(m_id));
        check_val("vector",    32'(bus.vector),    32'(m_vec));
        check_val("pending",   32'(bus.pending),   32'(m_pend));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_model();
        bus.mask_wr = 1'b0;
        bus.int_ack = 1'b0;
        bus.eoi     = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.req = 4'b0010; bus.mask_wr = 1'b0; bus.mask_data = 4'h0;
        bus.ie = 1'b1; bus.int_ack = 1'b0; bus.eoi = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        rst = 1'b0;

        // Lines already high at reset release are not edges
        step(); step();
        check_val("rst_hold_pending", 32'(bus.pending), 32'h0);
        check_val("rst_hold_intr",    32'(bus.intr),    32'h0);
        bus.req = 4'b0000; step();

        // Single source 2: one-cycle latch, then grant
        bus.req = 4'b0100; step();
        check_val("s2_pending", 32'(bus.pending), 32'h4);
        check_val("s2_intr_early", 32'(bus.intr), 32'h0);
        step();
        check_val("s2_intr", 32'(bus.intr), 32'h1);
        check_val("s2_id",   32'(bus.active_id), 32'h2);
        check_val("s2_vec",  32'(bus.vector), 32'h18);
        bus.int_ack = 1'b1; step();
        check_val("s2_ack_intr", 32'(bus.intr), 32'h0);
        check_val("s2_ack_busy", 32'(bus.busy), 32'h1);
        check_val("s2_ack_pend", 32'(bus.pending), 32'h0);
        bus.eoi = 1'b1; step();
        check_val("s2_eoi_busy", 32'(bus.busy), 32'h0);
        bus.req = 4'b0000; step();
        check_val("idle_after_eoi", 32'(bus.intr), 32'h0);

        // Two simultaneous sources: lower index first, then the other
        bus.req = 4'b1010; step(); step();
        check_val("dual_id1",  32'(bus.active_id), 32'h1);
        check_val("dual_vec1", 32'(bus.vector), 32'h10);
        bus.int_ack = 1'b1; step();
        bus.eoi = 1'b1; step();
        step();
        check_val("dual_intr3", 32'(bus.intr), 32'h1);
        check_val("dual_id3",   32'(bus.active_id), 32'h3);
        check_val("dual_vec3",  32'(bus.vector), 32'h20);
        bus.int_ack = 1'b1; step();
        bus.eoi = 1'b1; step();
        bus.req = 4'b0000; step();

        // Masked source latches but is not granted until unmasked
        bus.mask_wr = 1'b1; bus.mask_data = 4'b0001; step();
        bus.req = 4'b0001; step(); step();
        check_val("mask_pending", 32'(bus.pending), 32'h1);
        check_val("mask_no_intr", 32'(bus.intr), 32'h0);
        bus.mask_wr = 1'b1; bus.mask_data = 4'b0000; step(); step();
        check_val("unmask_intr", 32'(bus.intr), 32'h1);
        check_val("unmask_vec",  32'(bus.vector), 32'h08);

        // Retraction keeps the pending bit
        bus.ie = 1'b0; step();
        check_val("retract_intr", 32'(bus.intr), 32'h0);
        check_val("retract_pend", 32'(bus.pending), 32'h1);
        bus.ie = 1'b1; step();
        bus.int_ack = 1'b1; step();
        bus.eoi = 1'b1; bus.req = 4'b0000; step();

        // New edge on the acknowledged source wins over its clear
        bus.req = 4'b0010; step(); step();
        check_val("sameclr_id", 32'(bus.active_id), 32'h1);
        bus.req = 4'b0000; step();
        bus.req = 4'b0010; bus.int_ack = 1'b1; step();
        check_val("sameclr_pend", 32'(bus.pending), 32'h2);
        check_val("sameclr_busy", 32'(bus.busy), 32'h1);

        // Reset mid-service
        async_reset();
        check_val("rst_svc_busy", 32'(bus.busy), 32'h0);
        check_val("rst_svc_vec",  32'(bus.vector), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.ie      = ($urandom_range(0, 7) != 0);
            bus.int_ack = ($urandom_range(0, 2) == 0);
            bus.eoi     = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                bus.mask_wr   = 1'b1;
                bus.mask_data = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 299) == 0) async_reset();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/interrupt_request_arbiter.md
INTERRUPT_REQUEST_ARBITER -- requirements
Module: interrupt_request_arbiter

Interface
REQ-001 Parameter VEC_BASE, default 8'h08: vector issued for source 0.
REQ-002 Parameter VEC_STEP, default 8'h08: vector increment per source index.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  reset; asynchronous, active-high.
REQ-005 Req  input  4  interrupt request lines; rising-edge sensitive; bit 0 is highest priority.
REQ-006 MaskWr  input  1  one-cycle strobe that loads MaskData into the mask register.
REQ-007 MaskData  input  4  new mask value; 1 = source masked.
REQ-008 Ie  input  1  global interrupt enable level.
REQ-009 IntAck  input  1  one-cycle acknowledge pulse from the downstream interrupt controller.
REQ-010 Eoi  input  1  one-cycle end-of-interrupt pulse.
REQ-011 Intr  output  1  registered request to the downstream interrupt controller.
REQ-012 ActiveId  output  2  index of the granted source.
REQ-013 Vector  output  8  ISR address for the granted source.
REQ-014 Pending  output  4  latched request bits.
REQ-015 Busy  output  1  high while a granted interrupt is in service.

Function
REQ-016 Edge detection: a source bit is a rising edge when Req[i]=1 and the previous sample of Req[i]=0.
REQ-017 A detected edge on source i sets Pending[i] at that clock edge, independent of Mask and Ie.
REQ-018 Eligible set = Pending & ~Mask; the winner is the lowest eligible index.
REQ-019 The FSM has three states: IDLE, REQ and SERVICE.
REQ-020 In IDLE, when Ie=1 and the eligible set is non-zero: register ActiveId=winner, Vector=VEC_BASE+winner*VEC_STEP (8-bit, wrap-around) and Intr=1; go to REQ.
REQ-021 Latency: a Req rising edge sampled at edge k in IDLE gives Intr=1 after edge k+1.
REQ-022 In REQ: ActiveId and Vector stay frozen, and a later higher-priority request does not pre-empt.
REQ-023 In REQ, IntAck=1: clear Pending[ActiveId], set Intr=0 and Busy=1, go to SERVICE.
REQ-024 In REQ, Ie=0 without IntAck: set Intr=0 and return to IDLE; Pending is not cleared (retraction).
REQ-025 In REQ, IntAck=1 and Ie=0 in the same cycle: the acknowledge takes precedence.
REQ-026 In SERVICE, Eoi=1: set Busy=0 and go to IDLE; no nesting, and new edges keep latching.
REQ-027 IntAck outside REQ and Eoi outside SERVICE are ignored.
REQ-028 A new edge on source i and a clear of Pending[i] in the same cycle: the set wins, so Pending[i]=1.
REQ-029 MaskWr updates Mask at the next edge; a mask change in REQ does not affect the frozen grant.
REQ-030 ActiveId and Vector hold their last grant value in IDLE and SERVICE.

Reset
REQ-031 Rst=1 asynchronously forces: State=IDLE, Intr=0, Busy=0, ActiveId=0, Vector=8'h00, Pending=4'h0, Mask=4'h0.
REQ-032 Rst=1 also forces the previous-sample register to 4'hF, so lines already high at release are not edges.
REQ-033 Reset mid-REQ or mid-SERVICE aborts the grant; no acknowledge or EOI is required afterwards.

Structure
REQ-034 Package interrupt_pkg holds the FSM state encoding, the source count (4) and the default vector base and step constants.
REQ-035 Fixed-priority selection is one combinational sub-module, intr_prio_enc: inputs 4-bit eligible, outputs 2-bit index and valid.
REQ-036 All outputs are registered; there is no combinational path from any input to any output.

Verification
REQ-037 The bench covers these scenarios:
- Reset release with Req=4'b0010 held high -> Pending=0, Intr stays 0.
- Req[2] 0->1 at edge k, Ie=1 -> Pending=4'b0100 after edge k, Intr=1, ActiveId=2, Vector=8'h18 after edge k+1.
- IntAck -> Intr=0, Busy=1, Pending[2]=0; then Eoi -> Busy=0 and State=IDLE.
- Req[3] and Req[1] rise together -> grant id 1, Vector=8'h10; after Eoi -> grant id 3, Vector=8'h20.
- Mask=4'b0001 via MaskWr, Req[0] rises -> Pending=4'b0001, no Intr; unmask -> Intr=1, Vector=8'h08.
- REQ state, drop Ie -> Intr=0 and Pending kept; same-cycle Req[1] edge with IntAck on id 1 -> Pending[1]=1; Rst in SERVICE -> all outputs at reset values.
